// File: rtl/fsm_tri_tx.sv
// Serial frame transmitter: "111" preamble, "0" delimiter, then the payload
// MSB-first with a 0 stuffed after every "11". A "111" run therefore only
// ever appears in the preamble. All outputs are registered.
`timescale 1ns/1ps
module fsm_tri_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dataout,
    output logic             tx_active,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DELIM,
        DATA,
        STUFF,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [1:0]       pre_cnt, pre_cnt_nxt;
    logic [1:0]       ones_cnt, ones_cnt_nxt;
    logic             dataout_nxt;
    logic             din_ready_nxt;
    logic             tx_active_nxt;
    logic             frame_done_nxt;
    logic             accept;
    logic             sent_bit;

    assign accept   = din_valid & din_ready;
    assign sent_bit = shreg[WIDTH-1];

    // Next-state logic; bit_cnt counts consumed payload bits, so a stuff bit
    // after the last payload bit still finds bit_cnt == WIDTH and exits to GAP.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        pre_cnt_nxt  = pre_cnt;
        ones_cnt_nxt = ones_cnt;
        case (state)
            IDLE, GAP: begin
                if (accept) begin
                    state_nxt    = PRE;
                    shreg_nxt    = din;
                    bit_cnt_nxt  = '0;
                    pre_cnt_nxt  = '0;
                    ones_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PRE: begin
                if (pre_cnt == 2'd2) begin
                    state_nxt   = DELIM;
                    pre_cnt_nxt = '0;
                end else begin
                    pre_cnt_nxt = pre_cnt + 2'd1;
                end
            end
            DELIM: begin
                state_nxt    = DATA;
                ones_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
            end
            DATA: begin
                shreg_nxt    = {shreg[WIDTH-2:0], 1'b0};
                bit_cnt_nxt  = bit_cnt + CW'(1);
                ones_cnt_nxt = sent_bit ? ones_cnt + 2'd1 : 2'd0;
                if (sent_bit && (ones_cnt == 2'd1)) begin
                    state_nxt = STUFF;
                end else if (bit_cnt == CW'(WIDTH - 1)) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = DATA;
                end
            end
            STUFF: begin
                ones_cnt_nxt = '0;
                if (bit_cnt == CW'(WIDTH)) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = DATA;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered
    always_comb begin
        dataout_nxt    = 1'b0;
        din_ready_nxt  = 1'b0;
        tx_active_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        case (state_nxt)
            IDLE: begin
                din_ready_nxt = 1'b1;
            end
            PRE: begin
                dataout_nxt   = 1'b1;
                tx_active_nxt = 1'b1;
            end
            DELIM, STUFF: begin
                tx_active_nxt = 1'b1;
            end
            DATA: begin
                dataout_nxt   = shreg_nxt[WIDTH-1];
                tx_active_nxt = 1'b1;
            end
            GAP: begin
                din_ready_nxt  = 1'b1;
                frame_done_nxt = 1'b1;
            end
            default: begin
                din_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            pre_cnt    <= '0;
            ones_cnt   <= '0;
            dataout    <= 1'b0;
            din_ready  <= 1'b1;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            pre_cnt    <= pre_cnt_nxt;
            ones_cnt   <= ones_cnt_nxt;
            dataout    <= dataout_nxt;
            din_ready  <= din_ready_nxt;
            tx_active  <= tx_active_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_fsm_tri_tx.sv
// Testbench for fsm_tri_tx: table of hand-computed frames, back-to-back and
// mid-frame reset sequences, then random words decoded by de-stuffing.
`timescale 1ns/1ps
module tb_fsm_tri_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dataout;
    logic             tx_active;
    logic             frame_done;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int done_total = 0;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic [31:0]      stream;
        int               len;
    } vec_t;

    vec_t vecs[7];

    fsm_tri_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dataout    (dataout),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count every frame_done pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_total++;
    end

    // Keep the run bounded no matter what the DUT does
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic v);
        din       = d;
        din_valid = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic e_dout, input logic e_ready,
                               input logic e_active, input logic e_done);
        total_cnt++;
        if ({dataout, din_ready, tx_active, frame_done} === {e_dout, e_ready, e_active, e_done})
            pass_cnt++;
        else
            $display("[TB] FAIL %s: dout/rdy/act/done got %b%b%b%b, expected %b%b%b%b", name,
                     dataout, din_ready, tx_active, frame_done, e_dout, e_ready, e_active, e_done);
    endtask

    // Check one whole frame starting at its first preamble cycle; inputs for
    // the rest of the frame are set right after cycle 1 is sampled.
    task automatic checkFrame(input string tag, input logic [31:0] stream, input int len,
                              input logic [WIDTH-1:0] next_din, input logic next_valid);
        for (int k = 1; k <= len; k++) begin
            if (k > 1) step();
            checkOutput($sformatf("%s cyc%0d", tag, k), stream[len-k], k == len, k < len, k == len);
            if (k == 1) applyStimulus(next_din, next_valid);
        end
    endtask

    initial begin
        logic             bits[$];
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] dec;
        logic             got_done;
        logic             bad;
        logic             skip;
        int               nbits;
        int               run;
        int               ones;
        int               done_snap;

        vecs[0] = '{8'h00, 32'b1110_00000000_0, 13};
        vecs[1] = '{8'hFF, 32'b1110_110110110110_0, 17};
        vecs[2] = '{8'hB6, 32'b1110_1011001100_0, 15};
        vecs[3] = '{8'h81, 32'b1110_10000001_0, 13};
        vecs[4] = '{8'h7E, 32'b1110_01101101100_0, 16};
        vecs[5] = '{8'h03, 32'b1110_000000110_0, 14};
        vecs[6] = '{8'hA5, 32'b1110_10100101_0, 13};

        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        #12;
        checkOutput("reset values", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        checkOutput("idle after reset", 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].word, 1'b1);
            step();
            checkFrame($sformatf("vec%0d(%0h)", i, vecs[i].word), vecs[i].stream, vecs[i].len,
                       ~vecs[i].word, 1'b0);
            step();
            checkOutput($sformatf("vec%0d idle", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Back-to-back: valid stays high, din changes while busy
        applyStimulus(8'h81, 1'b1);
        step();
        checkFrame("b2b first", vecs[3].stream, vecs[3].len, 8'h7E, 1'b1);
        step();
        checkFrame("b2b second", vecs[4].stream, vecs[4].len, 8'h00, 1'b0);
        step();
        checkOutput("b2b idle", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset during the 6th DATA cycle of 8'h55, where dataout is 1
        applyStimulus(8'h55, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        for (int k = 2; k <= 10; k++) step();
        checkOutput("before mid reset", 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async mid reset", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("held in reset", 1'b0, 1'b1, 1'b0, 1'b0);
        #4;
        rst = 1'b0;
        applyStimulus(8'hB6, 1'b1);
        step();
        checkFrame("after reset", vecs[2].stream, vecs[2].len, 8'h00, 1'b0);
        step();
        checkOutput("after reset idle", 1'b0, 1'b1, 1'b0, 1'b0);

        // Random words: decode by dropping the 0 after every "11"
        done_snap = done_total;
        for (int n = 0; n < 200; n++) begin
            w = WIDTH'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            applyStimulus(w, 1'b1);
            step();
            applyStimulus(WIDTH'($urandom), 1'b0);
            bits.delete();
            got_done = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (c > 0) step();
                if (frame_done) begin
                    got_done = 1'b1;
                    break;
                end
                bits.push_back(dataout);
            end
            check($sformatf("rand%0d frame_done seen", n), 32'(got_done), 32'd1);
            if (bits.size() >= 4)
                check($sformatf("rand%0d preamble", n), {28'd0, bits[0], bits[1], bits[2], bits[3]}, 32'hE);
            else
                check($sformatf("rand%0d preamble length", n), 32'(bits.size()), 32'd4);
            dec   = '0;
            nbits = 0;
            run   = 0;
            ones  = 0;
            skip  = 1'b0;
            bad   = 1'b0;
            for (int i = 4; i < bits.size(); i++) begin
                ones = bits[i] ? ones + 1 : 0;
                if (ones >= 3) bad = 1'b1;
                if (skip) begin
                    if (bits[i]) bad = 1'b1;
                    skip = 1'b0;
                    run  = 0;
                end else begin
                    dec   = {dec[WIDTH-2:0], bits[i]};
                    nbits++;
                    run   = bits[i] ? run + 1 : 0;
                    if (run == 2) skip = 1'b1;
                end
            end
            if (skip) bad = 1'b1;
            check($sformatf("rand%0d decoded word", n), 32'(dec), 32'(w));
            check($sformatf("rand%0d payload bits/bad", n), {nbits[30:0], bad}, {31'(WIDTH), 1'b0});
        end
        step();
        check("rand frame_done pulses", 32'(done_total - done_snap), 32'd200);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
